// File: rtl/regfile_param.sv
// Parametrised MIPS register file with async reset, optional hardwired zero and a bulk-clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWriteSignal,
    input  logic              ClearReq,
    output logic              Busy,
    output logic              ClearDone
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic              clear_done;
    logic              wr_en;
    logic [DATA_W-1:0] regs [DEPTH];

    assign Busy      = (state == StClear);
    assign ClearDone = clear_done;

    // Writes to the hardwired-zero register are suppressed here so bypass sees the same rule.
    assign wr_en = RegWriteSignal && !Busy && !(ZERO_REG && (WriteReg == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            ptr        <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (ClearReq) begin
                        state <= StClear;
                        ptr   <= '0;
                    end
                end
                StClear: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state      <= StIdle;
                        clear_done <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[WriteReg] <= WriteData;
            end
            if (Busy) begin
                regs[ptr] <= '0;
            end
        end
    end

    always_comb begin
        ReadData1 = regs[ReadReg1];
        ReadData2 = regs[ReadReg2];
        if (ZERO_REG && (ReadReg1 == '0)) begin
            ReadData1 = '0;
        end
        if (ZERO_REG && (ReadReg2 == '0)) begin
            ReadData2 = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (ReadReg1 == WriteReg)) begin
            ReadData1 = WriteData;
        end
        if (wr_en && (ReadReg2 == WriteReg)) begin
            ReadData2 = WriteData;
        end
`else
`endif
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default 32x32 instance plus a 16-bit, 8-entry, no-zero-reg instance.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rr1, rr2, wa;
    logic [31:0] rd1, rd2, wd;
    logic        we, clr, busy, done;

    logic [2:0]  s_rr1, s_rr2, s_wa;
    logic [15:0] s_rd1, s_rd2, s_wd;
    logic        s_we, s_clr, s_busy, s_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    regfile_param dut (
        .clk(clk), .rst_n(rst_n),
        .ReadReg1(rr1), .ReadReg2(rr2), .ReadData1(rd1), .ReadData2(rd2),
        .WriteReg(wa), .WriteData(wd), .RegWriteSignal(we),
        .ClearReq(clr), .Busy(busy), .ClearDone(done)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .ReadReg1(s_rr1), .ReadReg2(s_rr2), .ReadData1(s_rd1), .ReadData2(s_rd2),
        .WriteReg(s_wa), .WriteData(s_wd), .RegWriteSignal(s_we),
        .ClearReq(s_clr), .Busy(s_busy), .ClearDone(s_done)
    );

    // Inputs change 1 time unit after each rising edge; outputs are sampled 4 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference read: storage plus zero-register rule plus optional write-first forwarding.
    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic w_en,
                                             input logic [4:0] w_a, input logic [31:0] w_d);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (w_en && a == w_a) return w_d;
`endif
        return model[a];
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; wa = 5'(i + 1); wd = $urandom | 32'h1;
            cyc();
        end
        we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl busy=%b done=%b required 0/0", busy, done);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(31 - i);
            #1;
            n_tests++;
            if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d rd1=%h rd2=%h required 0", i, rd1, rd2);
            end
        end
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        cyc();
        we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; rr1 = 5'd0;
        cyc();
        we = 1'b0;
        #4;
        n_tests++;
        if (rd1 !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_reg rd1=%h required 0", rd1);
        end
        cyc();
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 5'd5; wd = 32'h12345678;
        cyc();
        wa = 5'd31; wd = 32'hCAFEF00D;
        cyc();
        model[5] = 32'h12345678; model[31] = 32'hCAFEF00D;
        we = 1'b0; rr1 = 5'd5; rr2 = 5'd31;
        #4;
        n_tests++;
        if (rd1 !== 32'h12345678 || rd2 !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL write_read rd1=%h rd2=%h required 12345678/cafef00d", rd1, rd2);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            wa = 5'($urandom);
            wd = $urandom;
            rr1 = ($urandom % 4 == 0) ? wa : 5'($urandom);
            rr2 = ($urandom % 4 == 0) ? wa : 5'($urandom);
            e1 = ref_read(rr1, we, wa, wd);
            e2 = ref_read(rr2, we, wa, wd);
            #4;
            n_tests++;
            if (rd1 !== e1 || rd2 !== e2) begin
                n_fail++;
                $display("FAIL random n=%0d rd1=%h/%h rd2=%h/%h (actual/required)", n, rd1, e1, rd2, e2);
            end
            cyc();
            if (we && wa != 5'd0) model[wa] = wd;
        end
        we = 1'b0;
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd7; wd = 32'h1;
        cyc();
        model[7] = 32'h1;
        wd = 32'hA5A5A5A5; rr1 = 5'd7;
        #4;
        n_tests++;
`ifdef REGFILE_BYPASS_EN
        if (rd1 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_same rd1=%h required a5a5a5a5", rd1);
        end
`else
        if (rd1 !== 32'h1) begin
            n_fail++;
            $display("FAIL bypass_same rd1=%h required 00000001", rd1);
        end
`endif
        cyc();
        model[7] = 32'hA5A5A5A5;
        we = 1'b0;
        #4;
        n_tests++;
        if (rd1 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_next rd1=%h required a5a5a5a5", rd1);
        end
        cyc();
    endtask

    task automatic test_clear();
        logic [31:0] e2;
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'hFFFFFFFF;
            cyc();
        end
        we = 1'b0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        // Cycle c after the accepting edge: entries below c are cleared, entry c still holds old data.
        for (int c = 0; c < 36; c++) begin
            rr1 = 5'(c - 1);
            rr2 = 5'(c);
            we  = (c == 1);
            wa  = 5'd3;
            wd  = 32'h55;
            clr = (c == 4);
            #4;
            n_tests++;
            if (busy !== (c < 32) || done !== (c == 32)) begin
                n_fail++;
                $display("FAIL clear_hs c=%0d busy=%b done=%b required %b/%b",
                         c, busy, done, (c < 32), (c == 32));
            end
            if (c >= 1 && c < 32) begin
                e2 = (c == 0) ? 32'd0 : 32'hFFFFFFFF;
                n_tests++;
                if (rd1 !== 32'd0 || rd2 !== e2) begin
                    n_fail++;
                    $display("FAIL clear_prog c=%0d rd1=%h rd2=%h required 0/%h", c, rd1, rd2, e2);
                end
            end
            cyc();
        end
        we = 1'b0; clr = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(31 - i);
            #1;
            n_tests++;
            if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
                n_fail++;
                $display("FAIL clear_after addr=%0d rd1=%h rd2=%h required 0", i, rd1, rd2);
            end
        end
        cyc();
    endtask

    task automatic test_clear_with_write();
        clr = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h77;
        cyc();
        clr = 1'b0; we = 1'b0; rr1 = 5'd9;
        #4;
        n_tests++;
        if (rd1 !== 32'h77 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_wr_commit rd1=%h busy=%b required 00000077/1", rd1, busy);
        end
        repeat (32) cyc();
        #4;
        n_tests++;
        if (rd1 !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_wr_over rd1=%h busy=%b required 0/0", rd1, busy);
        end
        cyc();
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = $urandom | 32'h80000000;
            cyc();
        end
        we = 1'b0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (10) cyc();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clear_rst busy=%b done=%b required 0/0", busy, done);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(31 - i);
            #1;
            n_tests++;
            if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
                n_fail++;
                $display("FAIL mid_clear_read addr=%0d rd1=%h rd2=%h required 0", i, rd1, rd2);
            end
        end
        cyc();
        cyc();
        #4;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clear_idle busy=%b done=%b required 0/0", busy, done);
        end
        cyc();
    endtask

    task automatic test_sweep();
        int nb, nd;
        s_we = 1'b1; s_wa = 3'd0; s_wd = 16'hBEEF;
        cyc();
        s_we = 1'b0; s_rr1 = 3'd0;
        #4;
        n_tests++;
        if (s_rd1 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL sweep_reg0 rd1=%h required beef", s_rd1);
        end
        cyc();
        s_clr = 1'b1;
        cyc();
        s_clr = 1'b0;
        nb = 0; nd = 0;
        for (int c = 0; c < 14; c++) begin
            #4;
            if (s_busy) nb++;
            if (s_done) nd++;
            cyc();
        end
        n_tests++;
        if (nb != 8 || nd != 1) begin
            n_fail++;
            $display("FAIL sweep_clear busy_cycles=%0d done_pulses=%0d required 8/1", nb, nd);
        end
        n_tests++;
        if (s_rd1 !== 16'd0) begin
            n_fail++;
            $display("FAIL sweep_cleared rd1=%h required 0", s_rd1);
        end
    endtask

    initial begin
        rr1 = '0; rr2 = '0; wa = '0; wd = '0; we = 1'b0; clr = 1'b0;
        s_rr1 = '0; s_rr2 = '0; s_wa = '0; s_wd = '0; s_we = 1'b0; s_clr = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #12 rst_n = 1'b1;
        cyc();
        test_reset();
        test_write_read();
        test_bypass();
        test_random();
        test_clear();
        test_clear_with_write();
        test_reset_mid_clear();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
